periodic_event_monitor: RTL and testbench

Multi-channel periodic trigger generator with a measurement window. Each of NCH channels emits a one-cycle trigger pulse at its own programmable period and counts its own pulses. When a programmable window expires, the block publishes every channel's count as a snapshot, then raises a completion pulse one cycle later. It sits beside stimulus and checker blocks in the IPC/event infrastructure and provides cycle-accurate periodic events, activity counts and a window-done event for synchronising other agents.

---
 rtl/periodic_event_monitor.sv | 173 +++++++++++++++++
 tb/tb_periodic_event_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/periodic_event_monitor.sv
// periodic_event_monitor
// Multi-channel periodic trigger generator with a measurement window.
// Each channel pulses trig[i] whenever the window counter k is a multiple of
// its period and counts those pulses (saturating). At the end of each window
// the counts are published on cnt_snap with report_valid, followed one cycle
// later by done. In continuous mode the window re-arms until stop is seen.
module periodic_event_monitor #(
  parameter int NCH      = 2,
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 16,
  parameter int WIN_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    continuous,
  input  logic                    stop,
  input  logic [NCH-1:0]          ch_en,
  input  logic [NCH*PERIOD_W-1:0] period,
  input  logic [WIN_W-1:0]        window_len,
  output logic [NCH-1:0]          trig,
  output logic [NCH*CNT_W-1:0]    cnt_snap,
  output logic                    report_valid,
  output logic                    done,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT, S_DONE} state_t;

  localparam logic [WIN_W-1:0]    WIN_ONE = WIN_W'(1);
  localparam logic [PERIOD_W-1:0] PER_ONE = PERIOD_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

  state_t                r_state;
  logic                  r_cont;
  logic                  r_stop;
  logic [NCH-1:0]        r_en;
  logic [PERIOD_W-1:0]   r_per   [NCH];
  logic [PERIOD_W-1:0]   r_phase [NCH];
  logic [CNT_W-1:0]      r_cnt   [NCH];
  logic [WIN_W-1:0]      r_win;
  logic [WIN_W-1:0]      r_k;
  logic [NCH-1:0]        r_trig;
  logic [NCH*CNT_W-1:0]  r_snap;
  logic                  r_rv;
  logic                  r_done;
  logic                  r_busy;

  logic [NCH-1:0]        w_in_elig;
  logic [NCH-1:0]        w_lat_elig;
  logic [NCH-1:0]        w_next_trig;
  logic [PERIOD_W-1:0]   w_next_phase [NCH];
  logic                  w_last;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Channel eligibility, next phase and next-cycle trigger for every channel.
  always_comb begin
    w_in_elig   = '0;
    w_lat_elig  = '0;
    w_next_trig = '0;
    for (int i = 0; i < NCH; i++) begin
      w_in_elig[i]    = ch_en[i] && (period[i*PERIOD_W +: PERIOD_W] != '0);
      w_lat_elig[i]   = r_en[i] && (r_per[i] != '0);
      w_next_phase[i] = (r_phase[i] == r_per[i] - PER_ONE) ? '0 : r_phase[i] + PER_ONE;
      w_next_trig[i]  = w_lat_elig[i] && (w_next_phase[i] == '0);
    end
    w_last = (r_k == r_win - WIN_ONE);
  end

  // Control FSM with registered outputs; trig is computed one cycle ahead so
  // the pulse for run cycle k is visible during that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cont  <= 1'b0;
      r_stop  <= 1'b0;
      r_en    <= '0;
      r_win   <= '0;
      r_k     <= '0;
      r_trig  <= '0;
      r_snap  <= '0;
      r_rv    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_per[i]   <= '0;
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_rv   <= 1'b0;
      r_done <= 1'b0;
      r_trig <= '0;
      if (r_busy && r_cont && stop)
        r_stop <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cont <= continuous;
            r_en   <= ch_en;
            r_win  <= window_len;
            r_k    <= '0;
            r_busy <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
              r_per[i]   <= period[i*PERIOD_W +: PERIOD_W];
              r_phase[i] <= '0;
            end
            if (window_len == '0) begin
              r_state <= S_REPORT;
              r_rv    <= 1'b1;
              r_snap  <= '0;
              for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
            end else begin
              r_state <= S_RUN;
              r_trig  <= w_in_elig;
              for (int i = 0; i < NCH; i++) r_cnt[i] <= CNT_W'(w_in_elig[i]);
            end
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state <= S_REPORT;
            r_rv    <= 1'b1;
            for (int i = 0; i < NCH; i++) r_snap[i*CNT_W +: CNT_W] <= r_cnt[i];
          end else begin
            r_k    <= r_k + WIN_ONE;
            r_trig <= w_next_trig;
            for (int i = 0; i < NCH; i++) begin
              r_phase[i] <= w_next_phase[i];
              if (w_next_trig[i]) r_cnt[i] <= sat_inc(r_cnt[i]);
            end
          end
        end
        S_REPORT: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          // A stop arriving in this very cycle still ends the sequence.
          if (r_cont && !r_stop && !stop) begin
            r_k <= '0;
            for (int i = 0; i < NCH; i++) r_phase[i] <= '0;
            if (r_win == '0) begin
              r_state <= S_REPORT;
              r_rv    <= 1'b1;
              r_snap  <= '0;
              for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
            end else begin
              r_state <= S_RUN;
              r_trig  <= w_lat_elig;
              for (int i = 0; i < NCH; i++) r_cnt[i] <= CNT_W'(w_lat_elig[i]);
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_stop  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign trig         = r_trig;
  assign cnt_snap     = r_snap;
  assign report_valid = r_rv;
  assign done         = r_done;
  assign busy         = r_busy;

endmodule

// File: tb/tb_periodic_event_monitor.sv
// Scoreboard bench for periodic_event_monitor (NCH=2, CNT_W=4).
module tb_periodic_event_monitor;
  localparam int NCH = 2, PW = 16, CW = 4, WW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0, continuous = 1'b0, stop = 1'b0;
  logic [NCH-1:0]       ch_en = '0;
  logic [NCH*PW-1:0]    period = '0;
  logic [WW-1:0]        window_len = '0;
  logic [NCH-1:0]       trig;
  logic [NCH*CW-1:0]    cnt_snap;
  logic                 report_valid, done, busy;

  periodic_event_monitor #(.NCH(NCH), .PERIOD_W(PW), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .stop(stop),
    .ch_en(ch_en), .period(period), .window_len(window_len), .trig(trig),
    .cnt_snap(cnt_snap), .report_valid(report_valid), .done(done), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [7:0] snap; } rep_t;
  rep_t       rq[$];
  int         dq[$];
  logic [1:0] exp_trig[int];
  bit         exp_busy[int];
  logic [7:0] last_snap = '0;
  int nchecks = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Reference: channel i fires at every k in [0,W) with k % p == 0.
  task automatic model(input int E, input logic [1:0] en, input int p0, input int p1,
                       input int W, input int nwin);
    for (int j = 0; j < nwin; j++) begin
      int base, c0, c1;
      rep_t r;
      base = E + j * (W + 2);
      c0 = 0; c1 = 0;
      for (int k = 0; k < W; k++) begin
        logic [1:0] m;
        m = 2'b00;
        if (en[0] && p0 != 0 && (k % p0) == 0) begin m[0] = 1'b1; c0++; end
        if (en[1] && p1 != 0 && (k % p1) == 0) begin m[1] = 1'b1; c1++; end
        if (m != 2'b00) exp_trig[base + k] = m;
      end
      for (int b = base; b <= base + W + 1; b++) exp_busy[b] = 1'b1;
      r.c = base + W;
      r.snap = {4'(sat(c1)), 4'(sat(c0))};
      rq.push_back(r);
      dq.push_back(base + W + 1);
    end
  endtask

  // Monitor: per-cycle trig/busy/snapshot checks, pops on report_valid/done.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("trig", 64'(trig), 64'(exp_trig.exists(cyc) ? exp_trig[cyc] : 2'b00));
      chk("busy", 64'(busy), 64'(exp_busy.exists(cyc)));
      if (rq.size() > 0 && rq[0].c < cyc) begin
        chk("report_missing", 64'(rq[0].c), 64'(cyc));
        void'(rq.pop_front());
      end
      if (dq.size() > 0 && dq[0] < cyc) begin
        chk("done_missing", 64'(dq[0]), 64'(cyc));
        void'(dq.pop_front());
      end
      if (report_valid) begin
        if (rq.size() == 0) chk("report_unexpected", 64'(1), 64'(0));
        else begin
          rep_t r;
          r = rq.pop_front();
          chk("report_cycle", 64'(cyc), 64'(r.c));
          chk("cnt_snap", 64'(cnt_snap), 64'(r.snap));
          last_snap = r.snap;
        end
      end else begin
        chk("snap_hold", 64'(cnt_snap), 64'(last_snap));
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
        else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
      end
    end
  end

  task automatic issue_start(input logic [1:0] en, input int p0, input int p1, input int W,
                             input bit cont, output int E);
    @(negedge clk);
    ch_en = en;
    period = {p1[15:0], p0[15:0]};
    window_len = W[15:0];
    continuous = cont;
    start = 1'b1;
    E = cyc + 1;
  endtask

  task automatic scramble_cfg();
    ch_en = 2'($urandom);
    period = 32'($urandom);
    window_len = 16'($urandom);
    continuous = 1'($urandom);
  endtask

  task automatic run(input logic [1:0] en, input int p0, input int p1, input int W,
                     input bit cont, input int stop_win, input bit xstart);
    int E, nwin, last, stop_cyc, xs_cyc;
    issue_start(en, p0, p1, W, cont, E);
    nwin = cont ? stop_win + 1 : 1;
    model(E, en, p0, p1, W, nwin);
    last = E + nwin * (W + 2) - 1;
    stop_cyc = E + (cont ? stop_win * (W + 2) : 0) + int'($urandom_range(W + 1, 0));
    xs_cyc = xstart ? E + int'($urandom_range(last - E, 0)) : -10;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    while (cyc <= last) begin
      start = (cyc == xs_cyc);
      stop  = (cyc == stop_cyc);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    repeat ($urandom_range(3, 0)) @(negedge clk);
  endtask

  initial begin
    int E;
    // Reset state
    #12;
    chk("rst_trig", 64'(trig), 64'(0));
    chk("rst_snap", 64'(cnt_snap), 64'(0));
    chk("rst_rv", 64'(report_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed scenarios
    run(2'b11, 20, 40, 200, 1'b0, 0, 1'b0);
    run(2'b11, 3, 1, 10, 1'b1, 1, 1'b0);
    run(2'b01, 0, 5, 12, 1'b0, 0, 1'b0);
    run(2'b10, 0, 5, 12, 1'b0, 0, 1'b0);
    run(2'b01, 1, 0, 40, 1'b0, 0, 1'b0);
    run(2'b11, 4, 7, 0, 1'b0, 0, 1'b1);

    // Reset mid-window at k=7 after a nonzero snapshot exists
    run(2'b11, 2, 3, 9, 1'b0, 0, 1'b0);
    issue_start(2'b11, 20, 40, 200, 1'b0, E);
    model(E, 2'b11, 20, 40, 200, 1);
    @(negedge clk);
    start = 1'b0;
    while (cyc < E + 7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_trig.delete();
    exp_busy.delete();
    rq.delete();
    dq.delete();
    last_snap = '0;
    #1;
    chk("midrst_trig", 64'(trig), 64'(0));
    chk("midrst_snap", 64'(cnt_snap), 64'(0));
    chk("midrst_rv", 64'(report_valid), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(2'b11, 20, 40, 200, 1'b0, 0, 1'b0);

    // Randomized configurations
    for (int t = 0; t < 14; t++) begin
      run(2'($urandom), int'($urandom_range(9, 0)), int'($urandom_range(9, 0)),
          int'($urandom_range(30, 0)), 1'($urandom), int'($urandom_range(2, 0)),
          1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("reports_outstanding", 64'(rq.size()), 64'(0));
    chk("dones_outstanding", 64'(dq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
